// File: rtl/host_wg_dispatcher.sv
// Host work-group dispatcher: latches a kernel descriptor and issues one request per
// work-group, bounded by an in-flight credit limit, then drains completions.
module host_wg_dispatcher #(
  parameter int WG_ID_WIDTH    = 8,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int WF_COUNT_WIDTH = 4,
  parameter int REG_WIDTH      = 10,
  parameter int MAX_INFLIGHT   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [WG_ID_WIDTH:0]              cfg_num_wg,
  input  logic [WF_COUNT_WIDTH-1:0]         cfg_wf_per_wg,
  input  logic [7:0]                        cfg_wf_size,
  input  logic [MEM_ADDR_WIDTH-1:0]         cfg_start_pc,
  input  logic [MEM_ADDR_WIDTH-1:0]         cfg_pds_base,
  input  logic [MEM_ADDR_WIDTH-1:0]         cfg_pds_stride,
  input  logic [MEM_ADDR_WIDTH-1:0]         cfg_csr_knl,
  input  logic [REG_WIDTH-1:0]              cfg_vgpr_per_wf,
  input  logic [REG_WIDTH-1:0]              cfg_sgpr_per_wf,
  input  logic [15:0]                       cfg_lds_size,
  output logic                              host_req_valid,
  input  logic                              host_req_ready,
  output logic [WG_ID_WIDTH-1:0]            host_req_wg_id,
  output logic [WF_COUNT_WIDTH-1:0]         host_req_num_wf,
  output logic [7:0]                        host_req_wf_size,
  output logic [MEM_ADDR_WIDTH-1:0]         host_req_start_pc,
  output logic [MEM_ADDR_WIDTH-1:0]         host_req_pds_baseaddr,
  output logic [MEM_ADDR_WIDTH-1:0]         host_req_csr_knl,
  output logic [REG_WIDTH-1:0]              host_req_vgpr_size_total,
  output logic [REG_WIDTH-1:0]              host_req_sgpr_size_total,
  output logic [REG_WIDTH-1:0]              host_req_vgpr_size_per_wf,
  output logic [REG_WIDTH-1:0]              host_req_sgpr_size_per_wf,
  output logic [15:0]                       host_req_lds_size_total,
  input  logic                              host_rsp_valid,
  output logic                              host_rsp_ready,
  input  logic [WG_ID_WIDTH-1:0]            host_rsp_wg_id,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_spurious
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int CW = WG_ID_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             num_wg_q, issue_idx_q, cmpl_cnt_q;
  logic [IW-1:0]             inflight_q;
  logic                      err_q;
  logic [WF_COUNT_WIDTH-1:0] num_wf_q;
  logic [7:0]                wf_size_q;
  logic [MEM_ADDR_WIDTH-1:0] start_pc_q, pds_addr_q, pds_stride_q, csr_knl_q;
  logic [REG_WIDTH-1:0]      vgpr_tot_q, sgpr_tot_q, vgpr_per_wf_q, sgpr_per_wf_q;
  logic [15:0]               lds_q;
  logic                      cfg_fire, issue, last_issue, rsp_ok;

  assign cfg_fire       = (state_q == IDLE) && cfg_valid;
  assign host_req_valid = (state_q == ISSUE) && (issue_idx_q < num_wg_q)
                          && (inflight_q < IW'(MAX_INFLIGHT));
  assign issue          = host_req_valid && host_req_ready;
  assign last_issue     = issue && ((issue_idx_q + CW'(1)) == num_wg_q);
  // Only IDs already issued, with credits outstanding, count as real completions.
  assign rsp_ok         = host_rsp_valid && (inflight_q != '0)
                          && (CW'(host_rsp_wg_id) < issue_idx_q);

  assign cfg_ready      = (state_q == IDLE);
  assign host_rsp_ready = 1'b1;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign inflight       = inflight_q;
  assign err_spurious   = err_q;

  assign host_req_wg_id            = issue_idx_q[WG_ID_WIDTH-1:0];
  assign host_req_num_wf           = num_wf_q;
  assign host_req_wf_size          = wf_size_q;
  assign host_req_start_pc         = start_pc_q;
  assign host_req_pds_baseaddr     = pds_addr_q;
  assign host_req_csr_knl          = csr_knl_q;
  assign host_req_vgpr_size_total  = vgpr_tot_q;
  assign host_req_sgpr_size_total  = sgpr_tot_q;
  assign host_req_vgpr_size_per_wf = vgpr_per_wf_q;
  assign host_req_sgpr_size_per_wf = sgpr_per_wf_q;
  assign host_req_lds_size_total   = lds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_valid) state_d = (cfg_num_wg == '0) ? DONE : ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (cmpl_cnt_q == num_wg_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_wg_q      <= '0;
      issue_idx_q   <= '0;
      cmpl_cnt_q    <= '0;
      inflight_q    <= '0;
      err_q         <= 1'b0;
      num_wf_q      <= '0;
      wf_size_q     <= '0;
      start_pc_q    <= '0;
      pds_addr_q    <= '0;
      pds_stride_q  <= '0;
      csr_knl_q     <= '0;
      vgpr_tot_q    <= '0;
      sgpr_tot_q    <= '0;
      vgpr_per_wf_q <= '0;
      sgpr_per_wf_q <= '0;
      lds_q         <= '0;
    end else begin
      if (cfg_fire) begin
        num_wg_q      <= cfg_num_wg;
        issue_idx_q   <= '0;
        cmpl_cnt_q    <= '0;
        num_wf_q      <= cfg_wf_per_wg;
        wf_size_q     <= cfg_wf_size;
        start_pc_q    <= cfg_start_pc;
        pds_addr_q    <= cfg_pds_base;
        pds_stride_q  <= cfg_pds_stride;
        csr_knl_q     <= cfg_csr_knl;
        // Low REG_WIDTH bits of the product depend only on low operand bits.
        vgpr_tot_q    <= REG_WIDTH'(cfg_wf_per_wg) * cfg_vgpr_per_wf;
        sgpr_tot_q    <= REG_WIDTH'(cfg_wf_per_wg) * cfg_sgpr_per_wf;
        vgpr_per_wf_q <= cfg_vgpr_per_wf;
        sgpr_per_wf_q <= cfg_sgpr_per_wf;
        lds_q         <= cfg_lds_size;
      end else begin
        if (issue) begin
          issue_idx_q <= issue_idx_q + CW'(1);
          pds_addr_q  <= pds_addr_q + pds_stride_q;
        end
        if (rsp_ok) cmpl_cnt_q <= cmpl_cnt_q + CW'(1);
      end
      if (issue && !rsp_ok)      inflight_q <= inflight_q + IW'(1);
      else if (!issue && rsp_ok) inflight_q <= inflight_q - IW'(1);
      if (host_rsp_valid && !rsp_ok) err_q <= 1'b1;
    end
  end

endmodule
